// File: rtl/counter_ctrl_panel.sv
// counter_ctrl_panel: button front end for the 4-bit universal hex/decimal counter.
//
// Each of the four raw push-buttons goes through three stages:
//   - a 2-flop synchroniser
//   - a debouncer that accepts a new level only after it has held for DB_CYCLES clocks
//   - a press (rising-edge) detector
// The press pulses then drive the counter's control inputs. A prescaler makes the
// counter advance once every TICK_DIV clocks while running.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_clear  raw button: one-clock clear pulse per press
//   btn_mode   raw button: toggles hex/decimal
//   btn_dir    raw button: toggles up/down
//   btn_run    raw button: toggles run/stop
//   clear      to counter clear (held high during reset)
//   mode       to counter mode, 1 = hex, 0 = decimal
//   incr       to counter incr, 1 = up, 0 = down
//   pause      to counter pause, 0 = counter steps this cycle
//   running    status: free-running enabled
module counter_ctrl_panel #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned TICK_DIV  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_clear,
    input  logic btn_mode,
    input  logic btn_dir,
    input  logic btn_run,
    output logic clear,
    output logic mode,
    output logic incr,
    output logic pause,
    output logic running
);

    localparam int unsigned CntW = $clog2(DB_CYCLES) + 1;
    localparam int unsigned PscW = $clog2(TICK_DIV) + 1;
    localparam logic [CntW-1:0] DbLast  = CntW'(DB_CYCLES - 1);
    localparam logic [PscW-1:0] PscLast = PscW'(TICK_DIV - 1);

    // Button index: 0 = clear, 1 = mode, 2 = dir, 3 = run
    localparam int unsigned BClear = 0;
    localparam int unsigned BMode  = 1;
    localparam int unsigned BDir   = 2;
    localparam int unsigned BRun   = 3;

    logic [3:0]      btn_raw;
    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;
    logic [3:0]      stable_q;
    logic [3:0]      stable_dly_q;
    logic [CntW-1:0] db_cnt_q [4];
    logic [3:0]      press;
    logic [PscW-1:0] psc_q;
    logic [PscW-1:0] psc_d;

    assign btn_raw = {btn_run, btn_dir, btn_mode, btn_clear};

    // Synchronise and debounce all four buttons. Any sample that agrees with the
    // stable level restarts qualification, so a bounce never accumulates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (db_cnt_q[i] == DbLast) begin
                        stable_q[i] <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Only the debounced rising edge counts; releases are ignored.
    assign press = stable_q & ~stable_dly_q;

    // Prescaler restarts on clear, idles at zero while stopped, and is zeroed by
    // the run press that stops the counter.
    always_comb begin
        psc_d = psc_q;
        if (press[BClear] || press[BRun] || !running) begin
            psc_d = '0;
        end else if (psc_q == PscLast) begin
            psc_d = '0;
        end else begin
            psc_d = psc_q + 1'b1;
        end
    end

    // clear is high in reset: the counter has no reset of its own and is
    // initialised by the first clock edges it sees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear   <= 1'b1;
            mode    <= 1'b1;
            incr    <= 1'b1;
            running <= 1'b0;
            psc_q   <= '0;
        end else begin
            clear   <= press[BClear];
            mode    <= mode ^ press[BMode];
            incr    <= incr ^ press[BDir];
            running <= running ^ press[BRun];
            psc_q   <= psc_d;
        end
    end

    // Decoded from registers only.
    assign pause = ~(running & (psc_q == PscLast));

endmodule

// File: doc/counter_ctrl_panel.md
Name: counter_ctrl_panel

Overview:
Upstream control stage for the 4-bit universal up/down hex/decimal counter. Takes four raw push-buttons and conditions each one: synchronise, debounce, detect the press edge. Produces the counter's clear, mode, incr and pause inputs. Includes a prescaler so the counter advances once per TICK_DIV clocks while running.

Parameters:
DB_CYCLES, 4, consecutive clocks a synchronised button level must differ from the stable level before it is accepted (>=1)
TICK_DIV, 8, clocks per count step while running (>=1)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_clear  input  1  raw button, active-high, asynchronous to clk
btn_mode  input  1  raw button, toggles hex/decimal
btn_dir  input  1  raw button, toggles up/down
btn_run  input  1  raw button, toggles run/stop
clear  output  1  to counter clear
mode  output  1  to counter mode; 1 = hex, 0 = decimal
incr  output  1  to counter incr; 1 = up, 0 = down
pause  output  1  to counter pause; 0 = counter steps this cycle
running  output  1  status: free-running enabled

Behaviour:
- Reset (rst_n low, asynchronous):
  - all synchronisers, stable levels, debounce counters and prescaler = 0
  - mode = 1, incr = 1, running = 0, pause = 1
  - clear = 1 while in reset; the counter has no reset of its own, so this initialises it on the first clock edges
- First rising edge after rst_n deasserts: clear = 0, unless a clear press is pending (impossible from reset).
- Per button, synchroniser: 2-flop, sync1 then sync2.
- Per button, debounce: separate counter, width ceil(log2(DB_CYCLES))+1.
  - Each edge with sync2 != stable: if cnt == DB_CYCLES-1 then stable <= sync2 and cnt <= 0, else cnt++.
  - Each edge with sync2 == stable: cnt <= 0. Any bounce restarts qualification.
- Press detect: press = stable & ~stable_d, where stable_d is stable delayed one clock. Release edges do nothing.
- Latency: raw level first sampled at edge 0 -> output update at edge DB_CYCLES+2, i.e. the (DB_CYCLES+3)th edge.
- Registered updates on a press:
  - clear <= press_clear, so clear is exactly one clock wide per press
  - mode toggles on press_mode
  - incr toggles on press_dir
  - running toggles on press_run
- Prescaler psc, width ceil(log2(TICK_DIV))+1:
  - running = 0: psc held at 0
  - running = 1: psc increments and wraps from TICK_DIV-1 to 0
  - press_clear forces psc <= 0, overriding increment
  - a run press that stops the counter also zeroes psc
- pause = ~(running & (psc == TICK_DIV-1)), decoded from registers only, no input-to-output path.
  - With TICK_DIV = 1, pause = ~running.
- Simultaneous presses are independent. All toggles and the clear pulse occur on the same edge.
  - Clear with run on the same edge: clear pulses, running toggles, psc = 0.
- Mode or direction change while running takes effect on the next edge. Count value is not altered; the counter owns wrap-around.
- Button held indefinitely: one press only. A new press requires a debounced release first.
- rst_n asserted mid-operation: immediate return to reset values, including clear = 1 and pause = 1. Any partially debounced press is discarded.

Test Plan:
- Reset: rst_n low 3 clocks -> clear=1, pause=1, mode=1, incr=1, running=0. First edge after release -> clear=0.
- Run (DB_CYCLES=4, TICK_DIV=4): hold btn_run 20 clocks -> running=1 at edge 6 after first sample. pause then low exactly 1 of every 4 clocks. Second clean press -> running=0, pause stuck at 1.
- Bounce: btn_mode toggled 1,0,1,0 with 2-clock high pulses, then held high 10 clocks -> mode toggles exactly once, 1->0. Pulses of 3 clocks alone -> no change.
- Clear while running at psc=2: press btn_clear -> single 1-clock clear pulse, psc restarts at 0, next pause-low occurs 4 clocks later.
- Simultaneous: btn_dir and btn_run rise on the same edge -> incr and running change on the same edge. Held 30 clocks -> no further toggles.
- Async reset mid-debounce (cnt=2 on btn_run) and mid-run -> outputs to reset values without a clock edge. After release the press is not registered unless the button is re-qualified for the full DB_CYCLES.
